scan_master: RTL and testbench



---
 rtl/scan_master_pkg.sv | 59 +++++
 rtl/scan_phase_timer.sv | 43 ++++
 rtl/scan_master.sv | 180 ++++++++++++++++++
 tb/tb_scan_master.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_master_pkg.sv
// Shared types and constants for the scan chain host sequencer.
package scan_master_pkg;

    typedef enum logic [1:0] {
        SCAN_OP_ROTATE     = 2'd0,
        SCAN_OP_LOAD_CHIP  = 2'd1,
        SCAN_OP_LOAD_CHAIN = 2'd2,
        SCAN_OP_RESERVED   = 2'd3
    } scan_op_e;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ROTATE     = 3'd1,
        ST_LOAD_CHIP  = 3'd2,
        ST_LOAD_CHAIN = 3'd3,
        ST_DONE       = 3'd4
    } scan_state_e;

    localparam int unsigned ROT_PHASES     = 5;
    localparam int unsigned LDCHIP_PHASES  = 2;
    localparam int unsigned LDCHAIN_PHASES = 5;

    // Pad levels driven towards the chain during one phase.
    typedef struct packed {
        logic phi;
        logic phi_bar;
        logic data_in;
        logic load_chip;
        logic load_chain;
    } scan_pads_t;

    // Pad levels for a given operation state and phase index.
    function automatic scan_pads_t phase_pads(input scan_state_e st,
                                              input logic [2:0] p,
                                              input logic din);
        scan_pads_t pads;
        pads = '{phi: 1'b0, phi_bar: 1'b0, data_in: 1'b0, load_chip: 1'b0, load_chain: 1'b0};
        case (st)
            ST_ROTATE: begin
                pads.data_in = din;
                pads.phi     = (p == 3'd1);
                pads.phi_bar = (p == 3'd3);
            end
            ST_LOAD_CHIP: begin
                pads.load_chip = (p == 3'd1);
            end
            ST_LOAD_CHAIN: begin
                pads.load_chain = 1'b1;
                pads.phi        = (p == 3'd1);
                pads.phi_bar    = (p == 3'd3);
            end
            default: begin
                pads.phi = 1'b0;
            end
        endcase
        return pads;
    endfunction

endpackage

// File: rtl/scan_phase_timer.sv
// Phase timer: divides clk by PHASE_CYCLES and counts phases, wrapping at num_phases.
module scan_phase_timer
    import scan_master_pkg::*;
#(
    parameter int unsigned PHASE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       run,
    input  logic [2:0] num_phases,
    output logic [2:0] p,
    output logic       phase_last
);

    localparam int unsigned PW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PHASE_CYCLES - 1);

    logic [PW-1:0] presc_r;
    logic [2:0]    p_r;

    assign phase_last = (presc_r == PRESC_MAX);
    assign p          = p_r;

    // Prescaler and phase counter; restart from phase 0 whenever an op starts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_r <= '0;
            p_r     <= 3'd0;
        end else if (clear) begin
            presc_r <= '0;
            p_r     <= 3'd0;
        end else if (run) begin
            if (presc_r == PRESC_MAX) begin
                presc_r <= '0;
                p_r     <= (p_r == (num_phases - 3'd1)) ? 3'd0 : (p_r + 3'd1);
            end else begin
                presc_r <= presc_r + PW'(1);
            end
        end
    end

endmodule

// File: rtl/scan_master.sv
// Host-side sequencer turning parallel commands into two-phase scan chain pad waveforms.
module scan_master
    import scan_master_pkg::*;
#(
    parameter int unsigned CHAIN_LENGTH = 32,
    parameter int unsigned PHASE_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [CHAIN_LENGTH-1:0] cmd_wdata,
    output logic                    rsp_valid,
    output logic [CHAIN_LENGTH-1:0] rsp_rdata,
    output logic                    scan_phi,
    output logic                    scan_phi_bar,
    output logic                    scan_data_in,
    output logic                    scan_load_chip,
    output logic                    scan_load_chain,
    input  logic                    scan_data_out
);

    localparam int unsigned BW = $clog2(CHAIN_LENGTH);
    localparam logic [BW-1:0] B_LAST = BW'(CHAIN_LENGTH - 1);
    localparam scan_pads_t PADS_IDLE = '{phi: 1'b0, phi_bar: 1'b0, data_in: 1'b0,
                                         load_chip: 1'b0, load_chain: 1'b0};

    scan_state_e             state_r;
    logic                    cmd_ready_r;
    logic                    rsp_valid_r;
    logic [CHAIN_LENGTH-1:0] rsp_rdata_r;
    logic [CHAIN_LENGTH-1:0] sreg_r;
    logic [CHAIN_LENGTH-1:0] rdata_sr_r;
    logic [BW-1:0]           b_r;
    scan_pads_t              pads_r;

    logic                    accept_s;
    logic                    run_s;
    logic [2:0]              num_phases_s;
    logic [2:0]              p_s;
    logic                    phase_last_s;
    logic                    op_end_s;

    assign accept_s = (state_r == ST_IDLE) && cmd_valid && cmd_ready_r;
    assign op_end_s = phase_last_s && (p_s == (num_phases_s - 3'd1));

    // Phase count of the running operation and whether the timer should advance.
    always_comb begin
        num_phases_s = 3'(ROT_PHASES);
        run_s        = 1'b0;
        case (state_r)
            ST_ROTATE: begin
                num_phases_s = 3'(ROT_PHASES);
                run_s        = 1'b1;
            end
            ST_LOAD_CHIP: begin
                num_phases_s = 3'(LDCHIP_PHASES);
                run_s        = 1'b1;
            end
            ST_LOAD_CHAIN: begin
                num_phases_s = 3'(LDCHAIN_PHASES);
                run_s        = 1'b1;
            end
            default: begin
                num_phases_s = 3'(ROT_PHASES);
                run_s        = 1'b0;
            end
        endcase
    end

    scan_phase_timer #(
        .PHASE_CYCLES (PHASE_CYCLES)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (accept_s),
        .run        (run_s),
        .num_phases (num_phases_s),
        .p          (p_s),
        .phase_last (phase_last_s)
    );

    // Command sequencer; pads are loaded with the levels of the phase about to start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            cmd_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= '0;
            sreg_r      <= '0;
            rdata_sr_r  <= '0;
            b_r         <= '0;
            pads_r      <= PADS_IDLE;
        end else begin
            rsp_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        cmd_ready_r <= 1'b0;
                        sreg_r      <= cmd_wdata;
                        b_r         <= '0;
                        case (cmd_op)
                            SCAN_OP_ROTATE: begin
                                state_r <= ST_ROTATE;
                                pads_r  <= phase_pads(ST_ROTATE, 3'd0, cmd_wdata[0]);
                            end
                            SCAN_OP_LOAD_CHIP: begin
                                state_r <= ST_LOAD_CHIP;
                                pads_r  <= phase_pads(ST_LOAD_CHIP, 3'd0, 1'b0);
                            end
                            SCAN_OP_LOAD_CHAIN: begin
                                state_r <= ST_LOAD_CHAIN;
                                pads_r  <= phase_pads(ST_LOAD_CHAIN, 3'd0, 1'b0);
                            end
                            default: begin
                                // Reserved op completes immediately without touching the pads.
                                state_r     <= ST_DONE;
                                rsp_valid_r <= 1'b1;
                                pads_r      <= PADS_IDLE;
                            end
                        endcase
                    end else begin
                        cmd_ready_r <= 1'b1;
                    end
                end
                ST_ROTATE: begin
                    if (phase_last_s) begin
                        if (p_s == 3'd0) begin
                            rdata_sr_r <= {scan_data_out, rdata_sr_r[CHAIN_LENGTH-1:1]};
                        end
                        if (p_s == 3'(ROT_PHASES - 1)) begin
                            sreg_r <= sreg_r >> 1;
                            b_r    <= b_r + BW'(1);
                            if (b_r == B_LAST) begin
                                state_r     <= ST_DONE;
                                rsp_valid_r <= 1'b1;
                                rsp_rdata_r <= rdata_sr_r;
                                pads_r      <= PADS_IDLE;
                            end else begin
                                pads_r <= phase_pads(ST_ROTATE, 3'd0, sreg_r[1]);
                            end
                        end else begin
                            pads_r <= phase_pads(ST_ROTATE, p_s + 3'd1, sreg_r[0]);
                        end
                    end
                end
                ST_LOAD_CHIP, ST_LOAD_CHAIN: begin
                    if (op_end_s) begin
                        state_r     <= ST_DONE;
                        rsp_valid_r <= 1'b1;
                        pads_r      <= PADS_IDLE;
                    end else if (phase_last_s) begin
                        pads_r <= phase_pads(state_r, p_s + 3'd1, 1'b0);
                    end
                end
                ST_DONE: begin
                    state_r     <= ST_IDLE;
                    cmd_ready_r <= 1'b1;
                    pads_r      <= PADS_IDLE;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cmd_ready_r <= 1'b0;
                    pads_r      <= PADS_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready       = cmd_ready_r;
    assign rsp_valid       = rsp_valid_r;
    assign rsp_rdata       = rsp_rdata_r;
    assign scan_phi        = pads_r.phi;
    assign scan_phi_bar    = pads_r.phi_bar;
    assign scan_data_in    = pads_r.data_in;
    assign scan_load_chip  = pads_r.load_chip;
    assign scan_load_chain = pads_r.load_chain;

endmodule

// File: tb/tb_scan_master.sv
// Self-checking bench for scan_master with a behavioural 8-bit scan chain.
module tb_scan_master;

    localparam int CL = 8;
    localparam int PC = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [CL-1:0] cmd_wdata;
    logic          rsp_valid;
    logic [CL-1:0] rsp_rdata;
    logic          scan_phi, scan_phi_bar, scan_data_in, scan_load_chip, scan_load_chain;
    logic          scan_data_out;

    scan_master #(.CHAIN_LENGTH(CL), .PHASE_CYCLES(PC)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .cmd_wdata       (cmd_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_rdata       (rsp_rdata),
        .scan_phi        (scan_phi),
        .scan_phi_bar    (scan_phi_bar),
        .scan_data_in    (scan_data_in),
        .scan_load_chip  (scan_load_chip),
        .scan_load_chain (scan_load_chain),
        .scan_data_out   (scan_data_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural scan chain ----------------
    logic [7:0] chain = 8'h00, chip = 8'h00;
    logic       latch_bit = 1'b0;
    logic       phi_q = 1'b0, phib_q = 1'b0, ldc_q = 1'b0;
    logic [7:0] chain_pre_val = 8'h00, chip_pre_val = 8'h00;
    int         chain_pre_seq = 0, chip_pre_seq = 0;
    int         chain_seen = 0, chip_seen = 0;

    assign scan_data_out = chain[0];

    // Chain reacts to pad rising edges: phi latches data, phi_bar shifts, load pads transfer.
    always @(negedge clk) begin
        if (chain_pre_seq != chain_seen) begin
            chain      <= chain_pre_val;
            chain_seen <= chain_pre_seq;
        end
        if (chip_pre_seq != chip_seen) begin
            chip      <= chip_pre_val;
            chip_seen <= chip_pre_seq;
        end
        if (scan_phi && !phi_q) begin
            if (scan_load_chain) chain <= chip;
            else latch_bit <= scan_data_in;
        end
        if (scan_phi_bar && !phib_q && !scan_load_chain) chain <= {latch_bit, chain[7:1]};
        if (scan_load_chip && !ldc_q) chip <= chain;
        phi_q  <= scan_phi;
        phib_q <= scan_phi_bar;
        ldc_q  <= scan_load_chip;
    end

    // ---------------- transaction-level reference model ----------------
    logic       m_active = 1'b0, m_ready = 1'b0;
    int         m_t = 0, m_dur = 0;
    logic [1:0] m_op = 2'd0;
    logic [7:0] m_wd = 8'h00, m_snap = 8'h00, m_rdata = 8'h00;

    function automatic int op_dur(input logic [1:0] op);
        case (op)
            2'd0:    return 5 * PC * CL;
            2'd1:    return 2 * PC;
            2'd2:    return 5 * PC;
            default: return 0;
        endcase
    endfunction

    // Tracks time since acceptance; a rotate returns the chain contents seen at acceptance.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_active <= 1'b0;
            m_ready  <= 1'b0;
            m_t      <= 0;
            m_rdata  <= 8'h00;
        end else if (m_active) begin
            m_t <= m_t + 1;
            if (m_t + 1 == m_dur && m_op == 2'd0) m_rdata <= m_snap;
            if (m_t + 1 > m_dur) begin
                m_active <= 1'b0;
                m_ready  <= 1'b1;
            end
        end else if (m_ready && cmd_valid) begin
            m_active <= 1'b1;
            m_ready  <= 1'b0;
            m_t      <= 0;
            m_op     <= cmd_op;
            m_wd     <= cmd_wdata;
            m_snap   <= chain;
            m_dur    <= op_dur(cmd_op);
        end else begin
            m_ready <= 1'b1;
        end
    end

    logic cmp_en = 1'b0;

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        logic e_phi, e_phib, e_din, e_lchip, e_lchain, e_rv;
        int   ph, bitn;
        if (cmp_en) begin
            e_phi = 1'b0; e_phib = 1'b0; e_din = 1'b0; e_lchip = 1'b0; e_lchain = 1'b0; e_rv = 1'b0;
            if (m_active) begin
                if (m_t == m_dur) begin
                    e_rv = 1'b1;
                end else begin
                    case (m_op)
                        2'd0: begin
                            bitn   = m_t / (5 * PC);
                            ph     = (m_t / PC) % 5;
                            e_din  = m_wd[bitn];
                            e_phi  = (ph == 1);
                            e_phib = (ph == 3);
                        end
                        2'd1: begin
                            ph      = m_t / PC;
                            e_lchip = (ph == 1);
                        end
                        default: begin
                            ph       = m_t / PC;
                            e_lchain = 1'b1;
                            e_phi    = (ph == 1);
                            e_phib   = (ph == 3);
                        end
                    endcase
                end
            end
            check("cyc_phi", scan_phi, e_phi);
            check("cyc_phi_bar", scan_phi_bar, e_phib);
            check("cyc_data_in", scan_data_in, e_din);
            check("cyc_load_chip", scan_load_chip, e_lchip);
            check("cyc_load_chain", scan_load_chain, e_lchain);
            check("cyc_rsp_valid", rsp_valid, e_rv);
            check("cyc_cmd_ready", cmd_ready, m_ready);
            check("cyc_rsp_rdata", rsp_rdata, m_rdata);
            check("cyc_phi_overlap", scan_phi & scan_phi_bar, 1'b0);
        end
    end

    // ---------------- directed sequences ----------------
    int lat, phi_rise, phib_rise, phi_hi, phib_hi, lchip_hi, lchip_first, lchain_hi, overlap;

    task automatic wait_ready();
        int guard = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check("ready_wait", cmd_ready, 1'b1);
    endtask

    // Issue one command and record waveform statistics per cycle after acceptance.
    task automatic do_cmd(input logic [1:0] op, input logic [7:0] wd, input int stop_at);
        logic pphi = 1'b0, pphib = 1'b0;
        wait_ready();
        cmd_valid = 1'b1; cmd_op = op; cmd_wdata = wd;
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = -1; phi_rise = 0; phib_rise = 0; phi_hi = 0; phib_hi = 0;
        lchip_hi = 0; lchip_first = -1; lchain_hi = 0; overlap = 0;
        for (int k = 0; k < 400; k++) begin
            if (k > 0) @(negedge clk);
            if (k == stop_at) break;
            if (scan_phi && !pphi) phi_rise++;
            if (scan_phi_bar && !pphib) phib_rise++;
            if (scan_phi) phi_hi++;
            if (scan_phi_bar) phib_hi++;
            if (scan_phi && scan_phi_bar) overlap++;
            if (scan_load_chip) begin
                if (lchip_first < 0) lchip_first = k;
                lchip_hi++;
            end
            if (scan_load_chain) lchain_hi++;
            pphi = scan_phi;
            pphib = scan_phi_bar;
            if (rsp_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : main
        int r1, r2, ready_hi;
        logic [7:0] rd_at_r1;
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_wdata = 8'h00;
        repeat (2) @(posedge clk);
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_rsp_rdata", rsp_rdata, 8'h00);
        check("rst_pads", {scan_phi, scan_phi_bar, scan_data_in, scan_load_chip, scan_load_chain}, 5'b00000);

        // ROTATE A5 through a chain holding 3C
        chain_pre_val = 8'h3C; chain_pre_seq++;
        repeat (2) @(negedge clk);
        do_cmd(2'd0, 8'hA5, -1);
        check("rot_latency", lat, 80);
        check("rot_rdata", rsp_rdata, 8'h3C);
        check("rot_phi_pulses", phi_rise, 8);
        check("rot_phib_pulses", phib_rise, 8);
        check("rot_phi_cycles", phi_hi, 16);
        check("rot_phib_cycles", phib_hi, 16);
        check("rot_overlap", overlap, 0);
        @(negedge clk);
        check("rot_chain", chain, 8'hA5);

        // LOAD_CHIP
        do_cmd(2'd1, 8'h00, -1);
        check("ldchip_latency", lat, 4);
        check("ldchip_cycles", lchip_hi, 2);
        check("ldchip_start", lchip_first, 2);
        check("ldchip_phi", phi_hi + phib_hi, 0);
        @(negedge clk);
        check("ldchip_chip", chip, 8'hA5);

        // LOAD_CHAIN from chip value 5A, then read it out
        chip_pre_val = 8'h5A; chip_pre_seq++;
        repeat (2) @(negedge clk);
        do_cmd(2'd2, 8'h00, -1);
        check("ldchain_latency", lat, 10);
        check("ldchain_cycles", lchain_hi, 10);
        check("ldchain_phi", phi_rise, 1);
        check("ldchain_phib", phib_rise, 1);
        do_cmd(2'd0, 8'h00, -1);
        check("ldchain_rdata", rsp_rdata, 8'h5A);

        // Back-to-back with cmd_valid held: ROTATE 96 then reserved op
        chain_pre_val = 8'hC3; chain_pre_seq++;
        repeat (2) @(negedge clk);
        wait_ready();
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_wdata = 8'h96;
        @(negedge clk);
        cmd_op = 2'd3; cmd_wdata = 8'h11;
        r1 = -1; r2 = -1; ready_hi = 0; rd_at_r1 = 8'h00;
        for (int k = 0; k < 300; k++) begin
            if (k > 0) @(negedge clk);
            if (k < 80 && cmd_ready === 1'b1) ready_hi++;
            if (rsp_valid === 1'b1) begin
                if (r1 < 0) begin
                    r1 = k;
                    rd_at_r1 = rsp_rdata;
                end else begin
                    r2 = k;
                    cmd_valid = 1'b0;
                    break;
                end
            end
        end
        cmd_valid = 1'b0;
        check("b2b_ready_busy", ready_hi, 0);
        check("b2b_rot_rsp", r1, 80);
        check("b2b_rot_rdata", rd_at_r1, 8'hC3);
        check("b2b_rsvd_rsp", r2, 82);
        check("b2b_rsvd_rdata", rsp_rdata, 8'hC3);

        // Reset in the middle of a ROTATE 0F (chain holds 96)
        do_cmd(2'd0, 8'h0F, 30);
        #1 reset_n = 1'b0;
        #1;
        check("midrst_pads", {scan_phi, scan_phi_bar, scan_data_in, scan_load_chip, scan_load_chain}, 5'b00000);
        check("midrst_rsp_valid", rsp_valid, 1'b0);
        check("midrst_cmd_ready", cmd_ready, 1'b0);
        check("midrst_rdata", rsp_rdata, 8'h00);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        do_cmd(2'd0, 8'hFF, -1);
        check("postrst_latency", lat, 80);
        check("postrst_rdata", rsp_rdata, 8'hF2);
        @(negedge clk);
        check("postrst_chain", chain, 8'hFF);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
